// File: rtl/blr_gain_nch.sv
// blr_gain_nch: per-event baseline restore and gain stage.
//   For each event it reads 2^L pre-trigger samples per channel from the circular buffer,
//   averages them into a baseline, then streams (din - baseline) * gain, saturated to ADC_W
//   bits, towards the fast FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   RUN, event_rdy  acquisition enable (sampled in IDLE) and event-present level
//   cal_flag        calibration event: no clr_fast_fifo, no wr
//   skip_BLR        force baseline to 0
//   bl_len_log2     baseline length log2, clamped to BL_MAX_LOG2
//   gain            per-channel unsigned fixed-point gain, ch0 in LSBs
//   din             circular buffer data, valid the cycle after rd
//   rd, wr          circular buffer read strobe, fast FIFO write strobe
//   data_BL_valid   din is being accumulated into the baseline this cycle
//   data_valid      dout holds a restored sample
//   busy            event in progress
//   clr_fast_fifo   one-cycle fast FIFO clear at event start
//   bl_out, dout    baseline in use, restored output data
//   sat_flag        sticky per-channel saturation, cleared at event start
module blr_gain_nch #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned ADC_W       = 16,
   parameter int unsigned GAIN_W      = 16,
   parameter int unsigned GAIN_FRAC   = 12,
   parameter int unsigned BL_MAX_LOG2 = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   RUN,
   input  logic                   event_rdy,
   input  logic                   cal_flag,
   input  logic                   skip_BLR,
   input  logic [3:0]             bl_len_log2,
   input  logic [NCH*GAIN_W-1:0]  gain,
   input  logic [NCH*ADC_W-1:0]   din,
   output logic                   rd,
   output logic                   wr,
   output logic                   data_BL_valid,
   output logic                   data_valid,
   output logic                   busy,
   output logic                   clr_fast_fifo,
   output logic [NCH*ADC_W-1:0]   bl_out,
   output logic [NCH*ADC_W-1:0]   dout,
   output logic [NCH-1:0]         sat_flag
);

   localparam int unsigned AccW  = ADC_W + BL_MAX_LOG2;
   localparam int unsigned CntW  = BL_MAX_LOG2 + 1;
   localparam int unsigned DiffW = ADC_W + 1;
   localparam int unsigned ProdW = DiffW + GAIN_W + 1;
   localparam logic signed [ProdW-1:0] SatMax = ProdW'(2**(ADC_W-1) - 1);
   localparam logic signed [ProdW-1:0] SatMin = ~SatMax;

   typedef enum logic [2:0] {StIdle, StClr, StAcc, StDiv, StStream, StDrain} state_e;

   state_e                  state_q;
   logic [3:0]              len_q;
   logic [CntW-1:0]         rd_cnt_q;
   logic [CntW-1:0]         smp_cnt_q;
   logic                    rd_d1_q;
   logic                    s1_v_q;
   logic signed [AccW-1:0]  acc_q  [NCH];
   logic [GAIN_W-1:0]       gain_q [NCH];
   logic signed [DiffW-1:0] diff_q [NCH];

   logic [3:0]              len_clamp;
   logic [CntW-1:0]         n_smp;
   logic signed [ADC_W-1:0] din_s    [NCH];
   logic signed [ADC_W-1:0] bl_s     [NCH];
   logic signed [AccW-1:0]  acc_nxt  [NCH];
   logic signed [ADC_W-1:0] bl_calc  [NCH];
   logic signed [DiffW-1:0] diff_nxt [NCH];
   logic signed [ProdW-1:0] prod     [NCH];
   logic signed [ProdW-1:0] prod_sh  [NCH];
   logic signed [ADC_W-1:0] res      [NCH];
   logic [NCH-1:0]          sat;

   assign len_clamp = (bl_len_log2 > 4'(BL_MAX_LOG2)) ? 4'(BL_MAX_LOG2) : bl_len_log2;
   assign n_smp     = CntW'(1) << len_q;

   always_comb begin
      sat = '0;
      for (int c = 0; c < NCH; c++) begin
         din_s[c]    = din[c*ADC_W +: ADC_W];
         bl_s[c]     = bl_out[c*ADC_W +: ADC_W];
         acc_nxt[c]  = acc_q[c] + {{BL_MAX_LOG2{din_s[c][ADC_W-1]}}, din_s[c]};
         // Arithmetic shift floors the mean; it always fits back into ADC_W bits.
         bl_calc[c]  = skip_BLR ? '0 : ADC_W'(acc_q[c] >>> len_q);
         diff_nxt[c] = {din_s[c][ADC_W-1], din_s[c]} - {bl_s[c][ADC_W-1], bl_s[c]};
         // Both operands widened to ProdW so the truncated product is exact.
         prod[c]     = {{(ProdW-DiffW){diff_q[c][DiffW-1]}}, diff_q[c]}
                       * {{(ProdW-GAIN_W){1'b0}}, gain_q[c]};
         prod_sh[c]  = prod[c] >>> GAIN_FRAC;
         if (prod_sh[c] > SatMax) begin
            res[c] = SatMax[ADC_W-1:0];
            sat[c] = 1'b1;
         end else if (prod_sh[c] < SatMin) begin
            res[c] = SatMin[ADC_W-1:0];
            sat[c] = 1'b1;
         end else begin
            res[c] = prod_sh[c][ADC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         len_q         <= '0;
         rd_cnt_q      <= '0;
         smp_cnt_q     <= '0;
         rd_d1_q       <= 1'b0;
         s1_v_q        <= 1'b0;
         rd            <= 1'b0;
         wr            <= 1'b0;
         data_BL_valid <= 1'b0;
         data_valid    <= 1'b0;
         busy          <= 1'b0;
         clr_fast_fifo <= 1'b0;
         bl_out        <= '0;
         dout          <= '0;
         sat_flag      <= '0;
         for (int c = 0; c < NCH; c++) begin
            acc_q[c]  <= '0;
            gain_q[c] <= '0;
            diff_q[c] <= '0;
         end
      end else begin
         clr_fast_fifo <= 1'b0;
         case (state_q)
            StIdle: begin
               rd            <= 1'b0;
               wr            <= 1'b0;
               data_valid    <= 1'b0;
               data_BL_valid <= 1'b0;
               rd_d1_q       <= 1'b0;
               s1_v_q        <= 1'b0;
               if (event_rdy && RUN) begin
                  busy    <= 1'b1;
                  state_q <= StClr;
               end
            end
            StClr, StAcc, StDiv: begin
               if (!event_rdy) begin
                  // Event withdrawn before streaming: abort without any output.
                  rd            <= 1'b0;
                  data_BL_valid <= 1'b0;
                  busy          <= 1'b0;
                  rd_d1_q       <= 1'b0;
                  state_q       <= StIdle;
               end else if (state_q == StClr) begin
                  clr_fast_fifo <= ~cal_flag;
                  sat_flag      <= '0;
                  rd_cnt_q      <= '0;
                  smp_cnt_q     <= '0;
                  len_q         <= len_clamp;
                  rd            <= 1'b1;
                  for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
                  state_q       <= StAcc;
               end else if (state_q == StAcc) begin
                  rd_d1_q       <= rd;
                  data_BL_valid <= rd;
                  if (rd) begin
                     rd_cnt_q <= rd_cnt_q + CntW'(1);
                     if (rd_cnt_q == n_smp - CntW'(1)) rd <= 1'b0;
                  end
                  if (rd_d1_q) begin
                     for (int c = 0; c < NCH; c++) acc_q[c] <= acc_nxt[c];
                     smp_cnt_q <= smp_cnt_q + CntW'(1);
                     if (smp_cnt_q == n_smp - CntW'(1)) state_q <= StDiv;
                  end
               end else begin
                  for (int c = 0; c < NCH; c++) begin
                     bl_out[c*ADC_W +: ADC_W] <= bl_calc[c];
                     gain_q[c] <= gain[c*GAIN_W +: GAIN_W];
                  end
                  data_BL_valid <= 1'b0;
                  rd_d1_q       <= 1'b0;
                  rd            <= 1'b1;
                  state_q       <= StStream;
               end
            end
            StStream, StDrain: begin
               rd_d1_q <= rd;
               s1_v_q  <= rd_d1_q;
               if (rd_d1_q) begin
                  for (int c = 0; c < NCH; c++) diff_q[c] <= diff_nxt[c];
               end
               if (s1_v_q) begin
                  for (int c = 0; c < NCH; c++) begin
                     dout[c*ADC_W +: ADC_W] <= res[c];
                     if (sat[c]) sat_flag[c] <= 1'b1;
                  end
               end
               data_valid <= s1_v_q;
               wr         <= s1_v_q & ~cal_flag;
               if (state_q == StStream) begin
                  if (!event_rdy) begin
                     rd      <= 1'b0;
                     state_q <= StDrain;
                  end
               end else if (!rd_d1_q && !s1_v_q) begin
                  // Pipeline empty: the last sample is on dout this cycle.
                  data_valid <= 1'b0;
                  wr         <= 1'b0;
                  busy       <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_blr_gain_nch.sv
module tb_blr_gain_nch;

   localparam int NCH    = 4;
   localparam int ADC_W  = 16;
   localparam int GAIN_W = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  RUN = 1'b0;
   logic                  event_rdy = 1'b0;
   logic                  cal_flag = 1'b0;
   logic                  skip_BLR = 1'b0;
   logic [3:0]            bl_len_log2 = 4'd2;
   logic [NCH*GAIN_W-1:0] gain = '0;
   logic [NCH*ADC_W-1:0]  din = '0;
   logic                  rd, wr, data_BL_valid, data_valid, busy, clr_fast_fifo;
   logic [NCH*ADC_W-1:0]  bl_out, dout;
   logic [NCH-1:0]        sat_flag;

   blr_gain_nch dut (
      .clk           (clk),
      .rst           (rst),
      .RUN           (RUN),
      .event_rdy     (event_rdy),
      .cal_flag      (cal_flag),
      .skip_BLR      (skip_BLR),
      .bl_len_log2   (bl_len_log2),
      .gain          (gain),
      .din           (din),
      .rd            (rd),
      .wr            (wr),
      .data_BL_valid (data_BL_valid),
      .data_valid    (data_valid),
      .busy          (busy),
      .clr_fast_fifo (clr_fast_fifo),
      .bl_out        (bl_out),
      .dout          (dout),
      .sat_flag      (sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH*ADC_W-1:0] dout;
      logic [NCH*ADC_W-1:0] bl;
      int                   t;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   rd_idx = 0;
   int   ev_nbl = 4;
   int   ev_ns = 2;
   int   pat[4] = '{100, 102, 98, 100};
   int   st_din[2][4];
   int   st_exp[2][4];
   logic [NCH*ADC_W-1:0] ev_bl = '0;
   int   bl_seen = 0, clr_seen = 0, wr_seen = 0, dv_seen = 0;
   logic pend = 1'b0;

   function automatic logic [NCH*ADC_W-1:0] pack4(input int a, input int b, input int c,
                                                   input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic set_st(input int j, input int d0, input int d1, input int d2, input int d3,
                         input int e0, input int e1, input int e2, input int e3);
      st_din[j] = '{d0, d1, d2, d3};
      st_exp[j] = '{e0, e1, e2, e3};
   endtask

   always @(posedge clk) cyc++;

   // Circular buffer model: data for a read appears the cycle after rd.
   always begin
      int j;
      @(negedge clk);
      pend = rd;
      @(posedge clk);
      #1;
      if (pend) begin
         if (rd_idx < ev_nbl) begin
            din = pack4(pat[rd_idx%4], pat[rd_idx%4], pat[rd_idx%4], pat[rd_idx%4]);
         end else begin
            j = (rd_idx - ev_nbl) % ev_ns;
            din = pack4(st_din[j][0], st_din[j][1], st_din[j][2], st_din[j][3]);
            exp_q.push_back('{pack4(st_exp[j][0], st_exp[j][1], st_exp[j][2], st_exp[j][3]),
                              ev_bl, cyc});
         end
         rd_idx++;
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         if (data_BL_valid) bl_seen++;
         if (clr_fast_fifo) clr_seen++;
         if (wr) wr_seen++;
         if (data_valid) begin
            dv_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_dv", 64'(dout), 64'hdead);
            end else begin
               e = exp_q.pop_front();
               chk("dout", 64'(dout), 64'(e.dout));
               chk("bl_out", 64'(bl_out), 64'(e.bl));
               chk("latency", 64'(cyc - e.t), 64'd2);
               chk("wr_with_dv", {63'b0, wr}, {63'b0, ~cal_flag});
            end
         end
      end
   end

   task automatic run_event(input string nm, input int L, input logic skip, input logic cal,
                            input logic [63:0] g, input int blv, input int nreads,
                            input logic [3:0] sat_exp, input logic drop_run);
      int nbl;
      int t;
      nbl = 1 << ((L > 10) ? 10 : L);
      @(negedge clk);
      ev_nbl = nbl;
      ev_bl = pack4(blv, blv, blv, blv);
      rd_idx = 0;
      bl_seen = 0; clr_seen = 0; wr_seen = 0; dv_seen = 0;
      bl_len_log2 = 4'(L);
      skip_BLR = skip;
      cal_flag = cal;
      gain = g;
      event_rdy = 1'b1;
      if (drop_run) begin
         @(negedge clk);
         RUN = 1'b0;
      end
      t = 0;
      while (rd_idx < nbl + nreads && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_reads"}, 64'(rd_idx), 64'(nbl + nreads));
      event_rdy = 1'b0;
      RUN = 1'b1;
      t = 0;
      while (busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_busy_end"}, {63'b0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_bl_count"}, 64'(bl_seen), 64'(nbl));
      chk({nm, "_clr"}, 64'(clr_seen), cal ? 64'd0 : 64'd1);
      chk({nm, "_sat"}, 64'(sat_flag), 64'(sat_exp));
      chk({nm, "_dv_count"}, 64'(dv_seen), 64'(rd_idx - nbl));
      chk({nm, "_wr_count"}, 64'(wr_seen), cal ? 64'd0 : 64'(dv_seen));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctrl"}, {58'b0, rd, wr, data_BL_valid, data_valid, busy, clr_fast_fifo}, 64'd0);
      chk({nm, "_sat"}, 64'(sat_flag), 64'd0);
      chk({nm, "_bl"}, 64'(bl_out), 64'd0);
      chk({nm, "_dout"}, 64'(dout), 64'd0);
   endtask

   initial begin
      int t;
      int dv_snap;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      RUN = 1'b1;

      // T1: baseline 100, unity gain.
      set_st(0, 1100, 1100, 1100, 1100, 1000, 1000, 1000, 1000);
      set_st(1, 100, 0, -900, 5100, 0, -100, -1000, 5000);
      run_event("t1", 2, 1'b0, 1'b0, {4{16'h1000}}, 100, 4, 4'b0000, 1'b0);

      // T2: gain x2 / x0.5 with floor; RUN dropped mid-event.
      set_st(0, -100, 301, -1, 100, -400, 100, -51, 0);
      set_st(1, 100, 100, 100, 100, 0, 0, 0, 0);
      run_event("t2", 2, 1'b0, 1'b0, {16'h1000, 16'h0800, 16'h0800, 16'h2000}, 100, 4,
                4'b0000, 1'b1);

      // T3: baseline forced to 0, saturation at both rails and just inside them.
      set_st(0, 30000, -30000, 16383, -16384, 32767, -32768, 32766, -32768);
      set_st(1, 0, 0, 0, 0, 0, 0, 0, 0);
      run_event("t3", 2, 1'b1, 1'b0, {4{16'h2000}}, 0, 3, 4'b0011, 1'b0);

      // T4: calibration event; sat_flag must restart from 0.
      set_st(0, 1100, 200, 50, -32768, 1000, 100, -50, -32768);
      set_st(1, 100, 100, 100, 100, 0, 0, 0, 0);
      run_event("t4", 2, 1'b0, 1'b1, {4{16'h1000}}, 100, 4, 4'b1000, 1'b0);

      // T5: event withdrawn during baseline accumulation.
      @(negedge clk);
      ev_nbl = 4; rd_idx = 0;
      bl_seen = 0; clr_seen = 0; wr_seen = 0; dv_seen = 0;
      bl_len_log2 = 4'd2; cal_flag = 1'b0; skip_BLR = 1'b0;
      event_rdy = 1'b1;
      t = 0;
      while (bl_seen < 2 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      event_rdy = 1'b0;
      @(negedge clk);
      chk("t5_busy", {62'b0, busy, rd}, 64'd0);
      repeat (8) @(negedge clk);
      chk("t5_no_dv", 64'(dv_seen), 64'd0);
      chk("t5_no_wr", 64'(wr_seen), 64'd0);
      chk("t5_partial_bl", 64'(bl_seen < 4), 64'd1);
      chk("t5_clr", 64'(clr_seen), 64'd1);

      // T6: bl_len_log2=15 clamps to 1024 samples; reset mid-stream.
      set_st(0, 1100, 1100, 1100, 1100, 1000, 1000, 1000, 1000);
      set_st(1, 100, 0, -900, 5100, 0, -100, -1000, 5000);
      @(negedge clk);
      ev_nbl = 1024; ev_bl = pack4(100, 100, 100, 100); rd_idx = 0;
      bl_seen = 0; clr_seen = 0; wr_seen = 0; dv_seen = 0;
      bl_len_log2 = 4'd15; gain = {4{16'h1000}};
      event_rdy = 1'b1;
      t = 0;
      while (dv_seen < 2 && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("t6_dv_started", 64'(dv_seen >= 2), 64'd1);
      chk("t6_bl_count", 64'(bl_seen), 64'd1024);
      @(negedge clk);
      rst = 1'b1;
      event_rdy = 1'b0;
      @(negedge clk);
      chk_zero("t6_rst");
      rst = 1'b0;
      exp_q.delete();
      dv_snap = dv_seen;
      repeat (6) @(negedge clk);
      chk("t6_no_dv_after_rst", 64'(dv_seen), 64'(dv_snap));
      chk("t6_idle_after_rst", {62'b0, busy, rd}, 64'd0);

      // Recovery after reset.
      run_event("t7", 2, 1'b0, 1'b0, {4{16'h1000}}, 100, 4, 4'b0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
